// File: rtl/meas_accbuf_if.sv
// Signal bundle between the measurement front end / readout host and meas_accbuf.
// The master side drives the capture controls and readout address; the slave (meas_accbuf) returns status and read data.
interface meas_accbuf_if #(
  parameter int NCH = 4,
  parameter int DW  = 32,
  parameter int AW  = 12
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                  start;
  logic                  trig;
  logic                  wrap;
  logic [NCH-1:0]        done;
  logic [NCH*DW-1:0]     xacc;
  logic [NCH*DW-1:0]     yacc;
  logic [CW-1:0]         rd_chan;
  logic [AW-1:0]         rd_addr;
  logic [DW-1:0]         rd_data;
  logic [NCH-1:0]        full;
  logic [NCH-1:0]        wrapped;
  logic [NCH*(AW+1)-1:0] wptr;
  logic [NCH*16-1:0]     drops;

  modport master (
    output start, trig, wrap, done, xacc, yacc, rd_chan, rd_addr,
    input  rd_data, full, wrapped, wptr, drops
  );

  modport slave (
    input  start, trig, wrap, done, xacc, yacc, rd_chan, rd_addr,
    output rd_data, full, wrapped, wptr, drops
  );
endinterface

// File: rtl/meas_accbuf.sv
// Multi-channel measurement record buffer: each done pulse stores an X/Y word pair
// into a per-channel RAM, in stop-when-full or circular mode, with a shared registered readout port.
module meas_accbuf #(
  parameter int NCH = 4,
  parameter int DW  = 32,
  parameter int AW  = 12
) (
  input logic          clk,
  input logic          reset_n,
  meas_accbuf_if.slave bus
);
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DEPTH = 2 ** AW;
  localparam int PW    = AW + 1;

  typedef enum logic [1:0] {STOPPED, PEND, IDLE, WRY} state_t;

  logic [NCH*DW-1:0] rd_words;
  logic              rd_valid_q;
  logic [CW-1:0]     rd_sel_q;
  logic [DW-1:0]     rd_mux;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    state_t        state_q, state_d;
    logic [PW-1:0] wptr_q, wptr_d, wptr_adv;
    logic          wrapped_q, wrapped_d;
    logic [15:0]   drops_q, drops_d;
    logic [DW-1:0] y_q;
    logic          cap_y;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd_q;
    logic [DW-1:0] mem [DEPTH];

    assign wptr_adv = wptr_q + PW'(2);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q   <= STOPPED;
        wptr_q    <= '0;
        wrapped_q <= 1'b0;
        drops_q   <= '0;
      end else begin
        state_q   <= state_d;
        wptr_q    <= wptr_d;
        wrapped_q <= wrapped_d;
        drops_q   <= drops_d;
      end
    end

    // X is written straight from xacc on the done cycle; Y is held for the following WRY cycle.
    always_comb begin
      state_d   = state_q;
      wptr_d    = wptr_q;
      wrapped_d = wrapped_q;
      drops_d   = drops_q;
      cap_y     = 1'b0;
      we        = 1'b0;
      waddr     = wptr_q[AW-1:0];
      wdata     = bus.xacc[k*DW +: DW];
      case (state_q)
        STOPPED: begin
          if (bus.start) state_d = PEND;
        end
        PEND: begin
          if (!bus.start && bus.trig) begin
            wptr_d    = '0;
            wrapped_d = 1'b0;
            drops_d   = '0;
            state_d   = IDLE;
          end
        end
        IDLE: begin
          if (bus.start) begin
            state_d = PEND;
          end else if (bus.done[k]) begin
            we      = 1'b1;
            cap_y   = 1'b1;
            state_d = WRY;
          end
        end
        WRY: begin
          we    = 1'b1;
          waddr = wptr_q[AW-1:0] + AW'(1);
          wdata = y_q;
          if (wptr_adv[AW] && bus.wrap) begin
            wptr_d    = '0;
            wrapped_d = 1'b1;
          end else begin
            wptr_d = wptr_adv;
          end
          if (bus.start) state_d = PEND;
          else if (wptr_adv[AW] && !bus.wrap) state_d = STOPPED;
          else state_d = IDLE;
          if (!bus.start && bus.done[k] && drops_q != 16'hFFFF)
            drops_d = drops_q + 16'd1;
        end
        default: state_d = STOPPED;
      endcase
    end

    // Buffer RAM is deliberately not reset; the read register samples before the write lands (read-first).
    always_ff @(posedge clk) begin
      if (cap_y) y_q <= bus.yacc[k*DW +: DW];
      if (we) mem[waddr] <= wdata;
      rd_q <= mem[bus.rd_addr];
    end

    assign rd_words[k*DW +: DW] = rd_q;
    assign bus.full[k]          = (state_q == STOPPED) || (state_q == PEND);
    assign bus.wrapped[k]       = wrapped_q;
    assign bus.wptr[k*PW +: PW] = wptr_q;
    assign bus.drops[k*16 +: 16] = drops_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_sel_q   <= '0;
    end else begin
      rd_valid_q <= (int'(bus.rd_chan) < NCH);
      rd_sel_q   <= bus.rd_chan;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_sel_q == CW'(i)) rd_mux = rd_words[i*DW +: DW];
    end
  end

  assign bus.rd_data = rd_valid_q ? rd_mux : '0;
endmodule

// File: tb/tb_meas_accbuf.sv
// Table-driven bench for meas_accbuf (3 channels, 4-word buffers) with a read-data scoreboard
// and hand-written reset corner cases.
module tb_meas_accbuf;
  localparam int NCH = 3;
  localparam int DW  = 32;
  localparam int AW  = 2;
  localparam int CW  = 2;
  localparam int PW  = NCH * (AW + 1);

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  meas_accbuf_if #(.NCH(NCH), .DW(DW), .AW(AW)) bus ();

  meas_accbuf #(.NCH(NCH), .DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string             name;
    logic              st, tg, wr;
    logic [NCH-1:0]    done;
    logic [NCH*DW-1:0] x, y;
    logic [CW-1:0]     rc;
    logic [AW-1:0]     ra;
    logic              chk;
    logic [DW-1:0]     erd;
    logic [NCH-1:0]    efull;
    logic [PW-1:0]     ewptr;
    logic [15:0]       edrops;
    logic [NCH-1:0]    ewrapped;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  function automatic logic [PW-1:0] wp(input int a, input int b, input int c);
    return {3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic vec_t mk(input string n, input logic st, input logic tg, input logic wr,
                              input logic [NCH-1:0] d, input logic [NCH*DW-1:0] x,
                              input logic [NCH*DW-1:0] y, input logic [CW-1:0] rc,
                              input logic [AW-1:0] ra, input logic chk, input logic [DW-1:0] erd,
                              input logic [NCH-1:0] ef, input logic [PW-1:0] ew,
                              input logic [15:0] edr, input logic [NCH-1:0] ewr);
    vec_t v;
    v.name = n; v.st = st; v.tg = tg; v.wr = wr; v.done = d; v.x = x; v.y = y;
    v.rc = rc; v.ra = ra; v.chk = chk; v.erd = erd; v.efull = ef; v.ewptr = ew;
    v.edrops = edr; v.ewrapped = ewr;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; a read request queues its expected data for the next sample.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.start   = v.st;
    bus.trig    = v.tg;
    bus.wrap    = v.wr;
    bus.done    = v.done;
    bus.xacc    = v.x;
    bus.yacc    = v.y;
    bus.rd_chan = v.rc;
    bus.rd_addr = v.ra;
    if (v.chk) exp_q.push_back(v.erd);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    logic [DW-1:0] e;
    check({v.name, "_full"}, bus.full, v.efull);
    check({v.name, "_wptr"}, bus.wptr, v.ewptr);
    check({v.name, "_drops"}, bus.drops, {32'h0, v.edrops});
    check({v.name, "_wrapped"}, bus.wrapped, v.ewrapped);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({v.name, "_rd"}, bus.rd_data, e);
    end
  endtask

  task automatic checkReset(input string name);
    check({name, "_full"}, bus.full, 3'b111);
    check({name, "_wptr"}, bus.wptr, '0);
    check({name, "_drops"}, bus.drops, '0);
    check({name, "_wrapped"}, bus.wrapped, '0);
    check({name, "_rd"}, bus.rd_data, '0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    bus.start = 0; bus.trig = 0; bus.wrap = 0; bus.done = '0;
    bus.xacc = '0; bus.yacc = '0; bus.rd_chan = '0; bus.rd_addr = '0;

    //    name          st tg wr done    x        y     rc ra chk erd     full    wptr        drops wrapped
    tbl.push_back(mk("stop_done",  0,0,0,3'b001,'hAA,'hBB, 0,0,0,'h0,  3'b111,wp(0,0,0),0,3'b000));
    tbl.push_back(mk("start",      1,0,0,3'b000,'h0, 'h0,  0,0,0,'h0,  3'b111,wp(0,0,0),0,3'b000));
    tbl.push_back(mk("trig_pend",  0,1,0,3'b001,'hCC,'hDD, 0,0,0,'h0,  3'b000,wp(0,0,0),0,3'b000));
    tbl.push_back(mk("rec1_x",     0,0,0,3'b001,'h11,'h22, 0,0,0,'h0,  3'b000,wp(0,0,0),0,3'b000));
    tbl.push_back(mk("rec1_y",     0,0,0,3'b000,'h0, 'h0,  0,0,0,'h0,  3'b000,wp(2,0,0),0,3'b000));
    tbl.push_back(mk("rd_w0",      0,0,0,3'b000,'h0, 'h0,  0,0,1,'h11, 3'b000,wp(2,0,0),0,3'b000));
    tbl.push_back(mk("rd_w1",      0,0,0,3'b000,'h0, 'h0,  0,1,1,'h22, 3'b000,wp(2,0,0),0,3'b000));
    tbl.push_back(mk("rec2_x",     0,0,0,3'b001,'h33,'h44, 0,0,0,'h0,  3'b000,wp(2,0,0),0,3'b000));
    tbl.push_back(mk("rec2_y",     0,0,0,3'b000,'h0, 'h0,  0,0,0,'h0,  3'b001,wp(4,0,0),0,3'b000));
    tbl.push_back(mk("rec3_ign",   0,0,0,3'b001,'h55,'h56, 0,0,0,'h0,  3'b001,wp(4,0,0),0,3'b000));
    tbl.push_back(mk("rd_w2",      0,0,0,3'b000,'h0, 'h0,  0,2,1,'h33, 3'b001,wp(4,0,0),0,3'b000));
    tbl.push_back(mk("rd_w3",      0,0,0,3'b000,'h0, 'h0,  0,3,1,'h44, 3'b001,wp(4,0,0),0,3'b000));
    tbl.push_back(mk("rd_w0_kept", 0,0,0,3'b000,'h0, 'h0,  0,0,1,'h11, 3'b001,wp(4,0,0),0,3'b000));
    tbl.push_back(mk("rd_badch",   0,0,0,3'b000,'h0, 'h0,  3,0,1,'h0,  3'b001,wp(4,0,0),0,3'b000));
    tbl.push_back(mk("start_trig", 1,1,0,3'b000,'h0, 'h0,  0,0,0,'h0,  3'b111,wp(4,0,0),0,3'b000));
    tbl.push_back(mk("pend_hold",  0,0,0,3'b000,'h0, 'h0,  0,0,0,'h0,  3'b111,wp(4,0,0),0,3'b000));
    tbl.push_back(mk("trig_circ",  0,1,1,3'b000,'h0, 'h0,  0,0,0,'h0,  3'b000,wp(0,0,0),0,3'b000));
    tbl.push_back(mk("c1_x",       0,0,1,3'b001,'h61,'h62, 0,0,0,'h0,  3'b000,wp(0,0,0),0,3'b000));
    tbl.push_back(mk("c1_y",       0,0,1,3'b000,'h0, 'h0,  0,0,0,'h0,  3'b000,wp(2,0,0),0,3'b000));
    tbl.push_back(mk("c2_x",       0,0,1,3'b001,'h63,'h64, 0,0,0,'h0,  3'b000,wp(2,0,0),0,3'b000));
    tbl.push_back(mk("c2_y",       0,0,1,3'b000,'h0, 'h0,  0,0,0,'h0,  3'b000,wp(0,0,0),0,3'b001));
    tbl.push_back(mk("c3_x",       0,0,1,3'b001,'h65,'h66, 0,0,0,'h0,  3'b000,wp(0,0,0),0,3'b001));
    tbl.push_back(mk("c3_y",       0,0,1,3'b000,'h0, 'h0,  0,0,0,'h0,  3'b000,wp(2,0,0),0,3'b001));
    tbl.push_back(mk("rd_c0",      0,0,1,3'b000,'h0, 'h0,  0,0,1,'h65, 3'b000,wp(2,0,0),0,3'b001));
    tbl.push_back(mk("rd_c1",      0,0,1,3'b000,'h0, 'h0,  0,1,1,'h66, 3'b000,wp(2,0,0),0,3'b001));
    tbl.push_back(mk("rd_c3",      0,0,1,3'b000,'h0, 'h0,  0,3,1,'h64, 3'b000,wp(2,0,0),0,3'b001));
    tbl.push_back(mk("d1_x",       0,0,1,3'b001,'h71,'h72, 0,0,0,'h0,  3'b000,wp(2,0,0),0,3'b001));
    tbl.push_back(mk("d2_drop",    0,0,1,3'b001,'h99,'h9A, 0,0,0,'h0,  3'b000,wp(0,0,0),1,3'b001));
    tbl.push_back(mk("rd_d2",      0,0,1,3'b000,'h0, 'h0,  0,2,1,'h71, 3'b000,wp(0,0,0),1,3'b001));
    tbl.push_back(mk("rd_d3",      0,0,1,3'b000,'h0, 'h0,  0,3,1,'h72, 3'b000,wp(0,0,0),1,3'b001));
    tbl.push_back(mk("rf_x",       0,0,1,3'b001,'h81,'h82, 0,0,0,'h0,  3'b000,wp(0,0,0),1,3'b001));
    tbl.push_back(mk("rf_y_rd",    0,0,1,3'b000,'h0, 'h0,  0,1,1,'h66, 3'b000,wp(2,0,0),1,3'b001));
    tbl.push_back(mk("rf_new",     0,0,1,3'b000,'h0, 'h0,  0,1,1,'h82, 3'b000,wp(2,0,0),1,3'b001));
    tbl.push_back(mk("trig_idle",  0,1,1,3'b000,'h0, 'h0,  0,0,0,'h0,  3'b000,wp(2,0,0),1,3'b001));
    tbl.push_back(mk("multi_x",    0,0,1,3'b110,{32'hA2,32'hA1,32'h0},{32'hB2,32'hB1,32'h0},
                     0,0,0,'h0,  3'b000,wp(2,0,0),1,3'b001));
    tbl.push_back(mk("multi_y",    0,0,1,3'b000,'h0, 'h0,  0,0,0,'h0,  3'b000,wp(2,2,2),1,3'b001));
    tbl.push_back(mk("rd_ch1",     0,0,1,3'b000,'h0, 'h0,  1,0,1,'hA1, 3'b000,wp(2,2,2),1,3'b001));
    tbl.push_back(mk("rd_ch2",     0,0,1,3'b000,'h0, 'h0,  2,1,1,'hB2, 3'b000,wp(2,2,2),1,3'b001));

    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i]);
    end

    // Reset asserted while channel 0 is in WRY must abort the Y write.
    tbl.delete();
    tbl.push_back(mk("h_start",    1,0,0,3'b000,'h0, 'h0,  0,0,0,'h0,  3'b111,wp(2,2,2),1,3'b001));
    tbl.push_back(mk("h_trig",     0,1,0,3'b000,'h0, 'h0,  0,0,0,'h0,  3'b000,wp(0,0,0),0,3'b000));
    tbl.push_back(mk("h_x",        0,0,0,3'b001,'hC1,'hC2, 0,0,0,'h0,  3'b000,wp(0,0,0),0,3'b000));
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i]);
    end
    @(negedge clk);
    bus.done = '0;
    reset_n  = 1'b0;
    #1;
    checkReset("rst_async");
    @(posedge clk);
    #1;
    checkReset("rst_held");
    @(negedge clk);
    reset_n = 1'b1;

    tbl.delete();
    tbl.push_back(mk("post_done",  0,0,0,3'b001,'hEE,'hEF, 0,0,0,'h0,  3'b111,wp(0,0,0),0,3'b000));
    tbl.push_back(mk("rd_abort",   0,0,0,3'b000,'h0, 'h0,  0,1,1,'h82, 3'b111,wp(0,0,0),0,3'b000));
    tbl.push_back(mk("rd_xkept",   0,0,0,3'b000,'h0, 'h0,  0,0,1,'hC1, 3'b111,wp(0,0,0),0,3'b000));
    tbl.push_back(mk("post_start", 1,0,0,3'b000,'h0, 'h0,  0,0,0,'h0,  3'b111,wp(0,0,0),0,3'b000));
    tbl.push_back(mk("post_trig",  0,1,0,3'b000,'h0, 'h0,  0,0,0,'h0,  3'b000,wp(0,0,0),0,3'b000));
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i]);
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending reads expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/meas_accbuf.md
MEAS_ACCBUF -- requirements
Module: meas_accbuf

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NCH, 4, number of measurement channels (1..16).
- DW, 32, accumulator word width.
- AW, 12, per-channel buffer address width; DEPTH = 2**AW words; AW >= 1.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock for all logic.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, arm strobe for all channels.
- trig, in, 1, period trigger.
- wrap, in, 1, 0 = stop when full, 1 = circular.
- done, in, NCH, per-channel measurement-done pulse.
- xacc, in, NCH*DW, per-channel X result; channel k at [k*DW +: DW].
- yacc, in, NCH*DW, per-channel Y result, same packing.
- rd_chan, in, clog2(NCH) (min 1), readout channel select.
- rd_addr, in, AW, readout word address.
- rd_data, out, DW, readout word.
- full, out, NCH, channel not accepting records.
- wrapped, out, NCH, sticky: pointer has wrapped.
- wptr, out, NCH*(AW+1), per-channel write pointer.
- drops, out, NCH*16, per-channel saturating dropped-record count.

Function
REQ-003 Each channel SHALL have an FSM with states STOPPED, PEND, IDLE and WRY.
REQ-004 In any state, start SHALL move the channel to PEND next cycle. start has priority over trig and done in the same cycle.
REQ-005 In PEND, trig without start SHALL clear wptr to 0, clear wrapped, clear drops and enter IDLE. A done in that cycle SHALL be ignored.
REQ-006 In PEND and STOPPED, done SHALL be ignored and SHALL NOT count as a drop.
REQ-007 In IDLE, done SHALL register xacc/yacc for that channel, write X to word wptr that cycle and enter WRY.
REQ-008 In WRY, the registered Y SHALL be written to word wptr+1. wptr then advances by 2.
REQ-009 WRY SHALL always complete its Y write, including when start is asserted. The next state after WRY is PEND if start, else STOPPED if full, else IDLE.
REQ-010 A done in WRY SHALL be dropped and SHALL increment drops (saturating at 16'hFFFF).
REQ-011 Stop mode (wrap=0): when wptr reaches DEPTH (bit AW set), the channel SHALL enter STOPPED. Records are never split across the end of the buffer.
REQ-012 Circular mode (wrap=1): when the advance reaches DEPTH, wptr SHALL become 0 and wrapped SHALL set. The channel stays in IDLE.
REQ-013 full SHALL be 1 in STOPPED and PEND, and 0 in IDLE and WRY.
REQ-014 trig in IDLE, WRY or STOPPED SHALL have no effect.
REQ-015 wrap SHALL be sampled only at the pointer-advance decision. Changing wrap mid-capture SHALL affect only later wrap decisions.
REQ-016 Readout: rd_data SHALL be a registered read of channel rd_chan at rd_addr, with 1-cycle latency.
REQ-017 A read of a word being written in the same cycle SHALL return the old contents (read-first).
REQ-018 An rd_chan value >= NCH SHALL return 0.
REQ-019 Buffer contents SHALL NOT be cleared by reset or start. Only written words are defined.
REQ-020 Channels SHALL operate independently. Simultaneous done pulses on different channels SHALL all be captured.

Reset
REQ-021 While reset_n is low, each channel SHALL be STOPPED.
REQ-022 While reset_n is low, full SHALL be all 1, and wrapped, drops, wptr and rd_data SHALL be 0.
REQ-023 Reset deassertion SHALL be usable without a trig. Channels remain STOPPED until start followed by trig.
REQ-024 Reset asserted mid-WRY SHALL abort the Y write.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset, then done on ch0 -> no write, full[0]=1, drops=0.
- start; trig; done ch0 with x=0x11, y=0x22 -> words 0/1 = 0x11/0x22, wptr=2, full=0.
- AW=2, wrap=0, three records -> after the second record wptr=4 and full=1; the third is ignored, drops=0.
- AW=2, wrap=1, three records -> the third record is written at words 0/1, wrapped=1, wptr=2.
- done on two consecutive cycles -> the second is dropped, drops=1; start+trig same cycle -> trig ignored, PEND held until the next trig.
- Read at rd_addr=1 while it is written -> old value returned; the next read returns the new value.
